// File: rtl/arm_mem_pkg.sv
// Shared types and defaults for the memory-stage SRAM controller.
// Imported by the controller and its wait counter.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } sram_state_t;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
  localparam int          DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/sram_wait_counter.sv
// Counts the wait cycles of one 16-bit SRAM half-access.
// last is high on the final cycle of the half.
module sram_wait_counter
  import arm_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int CW = $clog2(WAIT_CYCLES);

  logic [CW-1:0] cnt;

  // Cycle counter, cleared between halves and while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = en & (cnt == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: one 32-bit load/store as two 16-bit
// SRAM accesses, stalling the pipeline through ready.
module mem_stage_sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        ALU_Res,
  input  logic [31:0]        Val_RM,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_DQ_out,
  input  logic [15:0]        SRAM_DQ_in,
  output logic               SRAM_DQ_oe,
  output logic               SRAM_WE_N
);

  sram_state_t state;
  sram_state_t state_nx;

  logic                 req;
  logic                 is_ld;
  logic                 busy;
  logic                 hi;
  logic                 last;
  logic [31:0]          offs;
  logic [SRAM_AW-2:0]   w;
  logic                 unused_offs;

  // Store wins when both enables are set
  assign req   = MEM_R_EN | MEM_W_EN;
  assign is_ld = MEM_R_EN & ~MEM_W_EN;
  assign busy  = (state == LOW) | (state == HIGH);
  assign hi    = (state == HIGH);

  assign offs = ALU_Res - BASE_ADDR;
  assign w    = offs[SRAM_AW:2];

  assign unused_offs = ^{offs[31:SRAM_AW+1], offs[1:0]};

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clear(~busy | last),
    .en   (busy),
    .last (last)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req)  state_nx = LOW;
      LOW:  if (last) state_nx = HIGH;
      HIGH: if (last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // SRAM pins; WE_N rises on the last count so the
  // address only moves while the strobe is high
  always_comb begin
    SRAM_ADDR   = '0;
    SRAM_DQ_out = '0;
    SRAM_DQ_oe  = 1'b0;
    SRAM_WE_N   = 1'b1;
    if (busy) begin
      SRAM_ADDR = {w, hi};
      if (MEM_W_EN) begin
        SRAM_DQ_out = hi ? Val_RM[31:16] : Val_RM[15:0];
        SRAM_DQ_oe  = 1'b1;
        SRAM_WE_N   = last;
      end
    end
  end

  // Load result, one half per phase, held between loads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= '0;
    end else if (is_ld & last) begin
      if (hi) begin
        read_data[31:16] <= SRAM_DQ_in;
      end else begin
        read_data[15:0] <= SRAM_DQ_in;
      end
    end
  end

  assign ready = ((state == IDLE) & ~req) | (state == DONE);

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a small SRAM
// model; a second instance runs with three wait cycles.
module tb_mem_stage_sram_ctrl;
  import arm_mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        r_en, w_en;
  logic [31:0] alu, val;
  logic [31:0] rd;
  logic        rdy;
  logic [17:0] s_addr;
  logic [15:0] s_dq_out, s_dq_in;
  logic        s_oe, s_we_n;

  logic        r_en3, w_en3;
  logic [31:0] alu3, val3;
  logic [31:0] rd3;
  logic        rdy3;
  logic [17:0] s_addr3;
  logic [15:0] s_dq_out3, s_dq_in3;
  logic        s_oe3, s_we_n3;

  logic [15:0] mem [0:255];
  int          cyc;
  int          errors;
  int          checks;

  mem_stage_sram_ctrl dut (
    .clk(clk), .rst(rst),
    .MEM_R_EN(r_en), .MEM_W_EN(w_en),
    .ALU_Res(alu), .Val_RM(val),
    .read_data(rd), .ready(rdy),
    .SRAM_ADDR(s_addr), .SRAM_DQ_out(s_dq_out),
    .SRAM_DQ_in(s_dq_in), .SRAM_DQ_oe(s_oe),
    .SRAM_WE_N(s_we_n)
  );

  mem_stage_sram_ctrl #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .MEM_R_EN(r_en3), .MEM_W_EN(w_en3),
    .ALU_Res(alu3), .Val_RM(val3),
    .read_data(rd3), .ready(rdy3),
    .SRAM_ADDR(s_addr3), .SRAM_DQ_out(s_dq_out3),
    .SRAM_DQ_in(s_dq_in3), .SRAM_DQ_oe(s_oe3),
    .SRAM_WE_N(s_we_n3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!s_we_n && s_oe) mem[s_addr[7:0]] <= s_dq_out;
  end

  assign s_dq_in  = mem[s_addr[7:0]];
  assign s_dq_in3 = 16'h0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic access(
    input  logic r, input logic wr,
    input  logic [31:0] a, input logic [31:0] d,
    input  logic keep,
    output int lows, output int wes, output int oe_bad,
    output logic [17:0] wa0, output logic [15:0] wd0,
    output logic [17:0] wa1, output logic [15:0] wd1,
    output logic [31:0] rd_done,
    output int t_start, output int t_done
  );
    @(posedge clk); #1;
    r_en = r; w_en = wr; alu = a; val = d;
    t_start = cyc;
    lows = 0; wes = 0; oe_bad = 0;
    wa0 = '0; wd0 = '0; wa1 = '0; wd1 = '0;
    rd_done = '0; t_done = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!s_we_n) begin
        if (!s_oe) oe_bad++;
        if (wes == 0) begin wa0 = s_addr; wd0 = s_dq_out; end
        if (wes == 1) begin wa1 = s_addr; wd1 = s_dq_out; end
        wes++;
      end
      if (rdy) begin
        rd_done = rd; t_done = cyc;
        break;
      end
      lows++;
    end
    if (!keep) begin
      @(posedge clk); #1;
      r_en = 1'b0; w_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    r_en = 0; w_en = 0; alu = 0; val = 0;
    r_en3 = 0; w_en3 = 0; alu3 = 0; val3 = 0;
    #12;
    if (rdy !== 1'b1) begin
      $display("FAIL rst_ready: got %b want 1", rdy); errors++;
    end
    checks++;
    if (rd !== 32'h0) begin
      $display("FAIL rst_rdata: got %h want 0", rd); errors++;
    end
    checks++;
    if ({s_addr, s_dq_out, s_oe, s_we_n} !== {18'h0, 16'h0, 1'b0, 1'b1}) begin
      $display("FAIL rst_pins: got addr=%h dq=%h oe=%b we_n=%b want 0 0 0 1",
               s_addr, s_dq_out, s_oe, s_we_n);
      errors++;
    end
    checks++;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_store();
    int lows, wes, oe_bad, t0, t1;
    logic [17:0] a0, a1;
    logic [15:0] d0, d1;
    logic [31:0] rdd;
    access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0,
           lows, wes, oe_bad, a0, d0, a1, d1, rdd, t0, t1);
    if (lows !== 5) begin
      $display("FAIL st_stall: got %0d want 5", lows); errors++;
    end
    checks++;
    if (wes !== 2 || oe_bad !== 0) begin
      $display("FAIL st_we_cnt: got we=%0d oe_bad=%0d want 2 0", wes, oe_bad);
      errors++;
    end
    checks++;
    if (a0 !== 18'd4 || d0 !== 16'hBEEF) begin
      $display("FAIL st_low: got %h/%h want 4/beef", a0, d0); errors++;
    end
    checks++;
    if (a1 !== 18'd5 || d1 !== 16'hDEAD) begin
      $display("FAIL st_high: got %h/%h want 5/dead", a1, d1); errors++;
    end
    checks++;
    @(negedge clk);
    if ({s_addr, s_dq_out, s_oe, s_we_n, rdy} !== {18'h0, 16'h0, 1'b0, 1'b1, 1'b1}) begin
      $display("FAIL st_idle_pins: got addr=%h dq=%h oe=%b we_n=%b rdy=%b want 0 0 0 1 1",
               s_addr, s_dq_out, s_oe, s_we_n, rdy);
      errors++;
    end
    checks++;
  endtask

  task automatic test_load();
    int lows, wes, oe_bad, t0, t1;
    logic [17:0] a0, a1;
    logic [15:0] d0, d1;
    logic [31:0] rdd;
    access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0,
           lows, wes, oe_bad, a0, d0, a1, d1, rdd, t0, t1);
    if (lows !== 5 || wes !== 0) begin
      $display("FAIL ld_stall: got lows=%0d we=%0d want 5 0", lows, wes);
      errors++;
    end
    checks++;
    if (rdd !== 32'hDEADBEEF) begin
      $display("FAIL ld_data: got %h want deadbeef", rdd); errors++;
    end
    checks++;
  endtask

  task automatic test_hold();
    repeat (10) @(negedge clk);
    if (rd !== 32'hDEADBEEF) begin
      $display("FAIL ld_hold: got %h want deadbeef", rd); errors++;
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    int l1, l2, w1, w2, ob1, ob2, s1, e1, s2, e2;
    logic [17:0] a0, a1;
    logic [15:0] d0, d1;
    logic [31:0] rd1, rd2;
    access(1'b0, 1'b1, 32'd1024, 32'h12345678, 1'b1,
           l1, w1, ob1, a0, d0, a1, d1, rd1, s1, e1);
    if (a0 !== 18'd0 || a1 !== 18'd1) begin
      $display("FAIL b2b_addr: got %h %h want 0 1", a0, a1); errors++;
    end
    checks++;
    access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0,
           l2, w2, ob2, a0, d0, a1, d1, rd2, s2, e2);
    if (s2 !== e1 + 1) begin
      $display("FAIL b2b_start: got cycle %0d want %0d", s2, e1 + 1); errors++;
    end
    checks++;
    if (e2 - s1 + 1 !== 12) begin
      $display("FAIL b2b_total: got %0d want 12", e2 - s1 + 1); errors++;
    end
    checks++;
    if (rd2 !== 32'h12345678) begin
      $display("FAIL b2b_data: got %h want 12345678", rd2); errors++;
    end
    checks++;
  endtask

  task automatic test_both_req();
    int lows, wes, oe_bad, t0, t1;
    logic [17:0] a0, a1;
    logic [15:0] d0, d1;
    logic [31:0] rdd;
    access(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 1'b0,
           lows, wes, oe_bad, a0, d0, a1, d1, rdd, t0, t1);
    if (wes !== 2 || mem[8] !== 16'hF00D || mem[9] !== 16'hCAFE) begin
      $display("FAIL both_write: got we=%0d m8=%h m9=%h want 2 f00d cafe",
               wes, mem[8], mem[9]);
      errors++;
    end
    checks++;
    if (rd !== 32'h12345678) begin
      $display("FAIL both_rdata: got %h want 12345678", rd); errors++;
    end
    checks++;
  endtask

  task automatic test_wrap_w3();
    int lows, wes;
    logic [17:0] fa, la;
    lows = 0; wes = 0; fa = '0; la = '0;
    @(posedge clk); #1;
    w_en3 = 1'b1; alu3 = 32'd1020; val3 = 32'h0BADCAFE;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!s_we_n3) begin
        if (wes == 0) fa = s_addr3;
        la = s_addr3;
        wes++;
      end
      if (rdy3) break;
      lows++;
    end
    @(posedge clk); #1;
    w_en3 = 1'b0;
    if (lows !== 7) begin
      $display("FAIL w3_stall: got %0d want 7", lows); errors++;
    end
    checks++;
    if (wes !== 4) begin
      $display("FAIL w3_we_cnt: got %0d want 4", wes); errors++;
    end
    checks++;
    if (fa !== 18'h3FFFE || la !== 18'h3FFFF) begin
      $display("FAIL w3_addr: got %h %h want 3fffe 3ffff", fa, la); errors++;
    end
    checks++;
  endtask

  task automatic test_abort_reset();
    int late_we;
    late_we = 0;
    @(posedge clk); #1;
    w_en = 1'b1; alu = 32'd1048; val = 32'hA5A55A5A;
    @(negedge clk);
    @(negedge clk);
    if (s_we_n !== 1'b0 || s_addr !== 18'd12) begin
      $display("FAIL ab_low_write: got we_n=%b addr=%h want 0 c", s_we_n, s_addr);
      errors++;
    end
    checks++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    if (s_we_n !== 1'b1 || s_oe !== 1'b0 || dut.state !== IDLE) begin
      $display("FAIL ab_immediate: got we_n=%b oe=%b st=%0d want 1 0 0",
               s_we_n, s_oe, dut.state);
      errors++;
    end
    checks++;
    w_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!s_we_n) late_we++;
    end
    if (late_we !== 0 || mem[13] === 16'hA5A5) begin
      $display("FAIL ab_no_high: got we=%0d m13=%h want 0 not a5a5",
               late_we, mem[13]);
      errors++;
    end
    checks++;
    if (rd !== 32'h0 || rdy !== 1'b1) begin
      $display("FAIL ab_after: got rd=%h rdy=%b want 0 1", rd, rdy); errors++;
    end
    checks++;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    test_reset();
    test_store();
    test_load();
    test_hold();
    test_back_to_back();
    test_both_req();
    test_wrap_w3();
    test_abort_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Memory-stage data-memory controller for the ARM pipeline, between the EX/MEM and MEM/WB pipeline registers. Turns one 32-bit load/store request into two 16-bit accesses on the external SRAM, with a programmable number of wait cycles per access. While a request is in progress, `ready` is held low, and the design uses it to freeze every pipeline register and the PC.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.
- `WAIT_CYCLES`, default 2, minimum 2: clock cycles per 16-bit half-access.
- `SRAM_AW`, default 18: SRAM address width.

Ports:
- `clk`, in, 1: sole clock. All state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `MEM_R_EN`, in, 1: load request (from the EX/MEM register).
- `MEM_W_EN`, in, 1: store request.
- `ALU_Res`, in, 32: byte address.
- `Val_RM`, in, 32: store data.
- `read_data`, out, 32: load result, sent to the MEM/WB register.
- `ready`, out, 1: 1 when no access is pending. 0 freezes the pipeline.
- `SRAM_ADDR`, out, `SRAM_AW`: halfword address.
- `SRAM_DQ_out`, out, 16: write data.
- `SRAM_DQ_in`, in, 16: read data.
- `SRAM_DQ_oe`, out, 1: drive enable for DQ; 1 only during write phases.
- `SRAM_WE_N`, out, 1: active-low write strobe.

## Operation
- Address calculation:
  - `offs = ALU_Res - BASE_ADDR`, 32-bit and truncating. Addresses below the base wrap modulo 2^32 with no error.
  - Word index `w = offs[SRAM_AW:2]`. Bits `offs[1:0]` are ignored.
  - Low half uses `SRAM_ADDR = {w, 1'b0}`; high half uses `{w, 1'b1}`. Truncate to `SRAM_AW` bits.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if `MEM_R_EN | MEM_W_EN`, go to LOW and clear the counter. Otherwise stay.
  - LOW: counter counts 0..`WAIT_CYCLES`-1. On the last count, go to HIGH and clear the counter.
  - HIGH: same count. On the last count, go to DONE.
  - DONE: always go to IDLE on the next cycle.
- Request priority: if `MEM_R_EN` and `MEM_W_EN` are both set, the store is performed and `read_data` is left unchanged.
- Request inputs are re-sampled every cycle. They must stay stable while `ready=0`; the frozen pipeline guarantees this.
- Stores:
  - LOW drives `Val_RM[15:0]`; HIGH drives `Val_RM[31:16]`.
  - `SRAM_DQ_oe=1` throughout both phases.
  - `SRAM_WE_N=0` on counts 0..`WAIT_CYCLES`-2 of each phase and 1 on the last count, so the address only changes while WE_N is high.
- Loads:
  - `SRAM_WE_N=1`, `SRAM_DQ_oe=0`.
  - `read_data[15:0]` is registered from `SRAM_DQ_in` on the last LOW cycle.
  - `read_data[31:16]` is registered on the last HIGH cycle.
  - `read_data` holds its value until the next load overwrites it.
- `ready` (combinational): `(state==IDLE & ~(MEM_R_EN|MEM_W_EN)) | state==DONE`.

## Timing
- Reset values, asserted asynchronously while `rst=0`:
  - state = IDLE, counter = 0
  - `read_data=0`, `SRAM_ADDR=0`, `SRAM_DQ_out=0`
  - `SRAM_DQ_oe=0`, `SRAM_WE_N=1`
  - `ready` follows the IDLE equation
- A reset during LOW or HIGH abandons the access immediately. No partial write continues after reset.
- Request first visible in IDLE at cycle 0:
  - LOW occupies cycles 1..W; HIGH occupies cycles W+1..2W; DONE is cycle 2W+1.
  - `ready` is 0 for cycles 0..2W and 1 in cycle 2W+1.
  - The pipeline advances at the end of cycle 2W+1.
  - With W=2, the stall is 5 cycles.
- Back-to-back requests: the next instruction's request appears in the cycle after DONE, while in IDLE, and starts a new access with no bubble beyond the IDLE cycle.
- Outside LOW and HIGH: `SRAM_ADDR`, `SRAM_DQ_out` and `SRAM_DQ_oe` return to 0, and `SRAM_WE_N` returns to 1.

## Structure
- Shared package `arm_mem_pkg`:
  - state enum `sram_state_t` (IDLE, LOW, HIGH, DONE)
  - default `BASE_ADDR`
  - default `WAIT_CYCLES`
- One sub-module, `sram_wait_counter`:
  - inputs: `clk`, `rst`, `clear`, `en`
  - parameter `WAIT_CYCLES`
  - output `last`
  - counter width is `$clog2(WAIT_CYCLES)`
- FSM, address/data muxing and the `read_data` registers stay in the top module.

## Test plan
- Store `Val_RM=32'hDEADBEEF` at `ALU_Res=1032`, W=2:
  - `SRAM_ADDR=4` with DQ `16'hBEEF`, then `SRAM_ADDR=5` with DQ `16'hDEAD`.
  - One WE_N-low cycle per half.
  - `ready` low for 5 cycles.
- Load from 1032 with the SRAM model returning `16'hBEEF` at address 4 and `16'hDEAD` at address 5:
  - `read_data=32'hDEADBEEF` in DONE.
  - `read_data` still holds that value 10 cycles later with no request.
- Back-to-back store to 1024 then load from 1024:
  - Second access starts the cycle after DONE.
  - Load returns the stored word.
  - Total of 12 cycles from the first request to the second DONE.
- `MEM_R_EN` and `MEM_W_EN` both high:
  - A write occurs.
  - `read_data` is unchanged.
- `rst` driven low in the second LOW cycle of a store:
  - `SRAM_WE_N=1`, `SRAM_DQ_oe=0` and state IDLE immediately.
  - No HIGH-phase write occurs after reset releases.
- `ALU_Res=1020` with W=3:
  - `offs` wraps to `32'hFFFFFFFC`.
  - `SRAM_ADDR` = `18'h3FFFE` then `18'h3FFFF`.
  - `ready` low for 7 cycles.
